// File: rtl/vector_issue_fifo_pkg.sv
// Shared definitions for the vector issue FIFO: default entry width,
// the entry type and the pointer-width helper.
package vector_issue_pkg;

  // Default width of one packed entry (instruction word plus scalar operands).
  localparam int DEFAULT_DATA_FROM_SCALAR = 96;

  typedef logic [DEFAULT_DATA_FROM_SCALAR-1:0] vec_issue_entry_t;

  // Pointer width for a circular buffer of 'depth' entries (never below 1 bit).
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/vector_issue_fifo_ptr_ctrl.sv
// Pointer/occupancy controller for the vector issue FIFO. Owns wr_ptr,
// rd_ptr and count, and decodes full/empty from count (never from pointer
// equality). Flush wins over push and pop.
module fifo_ptr_ctrl
  import vector_issue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PW    = ptr_width(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic push_ok;
  logic pop_ok;

  // Occupancy decode; requests are re-qualified here so count can never
  // overflow or underflow whatever the caller drives.
  always_comb begin
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
    push_ok = push && !full;
    pop_ok  = pop && !empty;
  end

  // Pointer and count registers; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vector_issue_fifo.sv
// Vector issue FIFO: buffers packed vector instructions from the scalar
// pipeline and presents the head entry to the vector dispatch stage.
//
// Handshakes (both sides, strict valid/ready): a transfer happens on a
// rising clk edge when valid and ready are both high. valid_fifo never
// depends on ready; push_ready never depends on push_valid or on a
// same-cycle pop (a full FIFO always refuses).
//
// Optional build macro VECTOR_ISSUE_FIFO_BYPASS_EN: when the FIFO is empty
// an offered entry is presented combinationally in the same cycle and, if
// dispatch takes it, it is never written. Without the macro an entry
// reaches the head one cycle after it is pushed.
module vector_issue_fifo
  import vector_issue_pkg::*;
#(
  parameter int DATA_FROM_SCALAR   = DEFAULT_DATA_FROM_SCALAR,
  parameter int DEPTH              = 8,
  parameter int ALMOST_FULL_THRESH = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push_valid,
  input  logic [DATA_FROM_SCALAR-1:0] push_data,
  output logic                        push_ready,
  input  logic                        flush,
  output logic [DATA_FROM_SCALAR-1:0] instruction,
  output logic                        valid_fifo,
  input  logic                        ready,
  output logic                        almost_full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_FROM_SCALAR-1:0] mem [DEPTH];
  logic [PW-1:0]               wr_ptr;
  logic [PW-1:0]               rd_ptr;
  logic                        full;
  logic                        push_en;
  logic                        pop_en;
  logic                        bypass_hit;

  fifo_ptr_ctrl #(
    .DEPTH (DEPTH),
    .PW    (PW),
    .CW    (CW)
  ) u_ptr_ctrl (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .push   (push_en),
    .pop    (pop_en),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  // Handshake decode, head presentation and flag outputs.
  always_comb begin
`ifdef VECTOR_ISSUE_FIFO_BYPASS_EN
    // An empty FIFO forwards the offered entry; flush suppresses it.
    bypass_hit = empty && push_valid && !flush;
`else
    bypass_hit = 1'b0;
`endif
    push_ready  = !full;
    valid_fifo  = !empty || bypass_hit;
    almost_full = (count >= CW'(ALMOST_FULL_THRESH));
    // A bypassed entry taken by dispatch in the same cycle is never stored.
    push_en     = push_valid && push_ready && !flush && !(bypass_hit && ready);
    // Only stored entries are popped; flush priority is applied in the controller.
    pop_en      = ready && !empty;
    instruction = '0;
    if (!empty) begin
      instruction = mem[rd_ptr];
    end else if (bypass_hit) begin
      instruction = push_data;
    end
  end

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: tb/tb_vector_issue_fifo.sv
// Self-checking bench for vector_issue_fifo: directed scenarios with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_vector_issue_fifo;

  localparam int W      = 96;
  localparam int DEPTH  = 8;
  localparam int THRESH = 6;
`ifdef VECTOR_ISSUE_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic         clk;
  logic         rst;
  logic         push_valid;
  logic [W-1:0] push_data;
  logic         push_ready;
  logic         flush;
  logic [W-1:0] instruction;
  logic         valid_fifo;
  logic         ready;
  logic         almost_full;
  logic         empty;
  logic [3:0]   count;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  vector_issue_fifo #(
    .DATA_FROM_SCALAR   (W),
    .DEPTH              (DEPTH),
    .ALMOST_FULL_THRESH (THRESH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .push_valid  (push_valid),
    .push_data   (push_data),
    .push_ready  (push_ready),
    .flush       (flush),
    .instruction (instruction),
    .valid_fifo  (valid_fifo),
    .ready       (ready),
    .almost_full (almost_full),
    .empty       (empty),
    .count       (count)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: the FIFO contents as a plain queue, head at index 0.
  logic [W-1:0] exp_q[$];
  bit           m_pop;
  bit           m_push;
  bit           m_take;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
    end else if (flush) begin
      exp_q.delete();
    end else begin
      m_take = BYP && (exp_q.size() == 0) && push_valid && ready;
      m_pop  = (exp_q.size() > 0) && ready;
      m_push = push_valid && (exp_q.size() < DEPTH) && !m_take;
      if (m_pop)  void'(exp_q.pop_front());
      if (m_push) exp_q.push_back(push_data);
    end
  end

  // Compare process: every negedge outside reset, outputs must match the model.
  logic [W-1:0] e_instr;
  bit           e_valid;
  always @(negedge clk) begin
    if (!rst) begin
      e_valid = (exp_q.size() > 0) || (BYP && push_valid && !flush);
      if (exp_q.size() > 0)                   e_instr = exp_q[0];
      else if (BYP && push_valid && !flush)   e_instr = push_data;
      else                                    e_instr = '0;
      chk("valid_fifo",  W'(valid_fifo),  W'(e_valid));
      chk("instruction", instruction,     e_instr);
      chk("count",       W'(count),       W'(exp_q.size()));
      chk("push_ready",  W'(push_ready),  W'(exp_q.size() < DEPTH));
      chk("empty",       W'(empty),       W'(exp_q.size() == 0));
      chk("almost_full", W'(almost_full), W'(exp_q.size() >= THRESH));
    end
  end

  // ---------------- driver tasks ----------------
  // Apply inputs for one clock cycle; returns just after the edge.
  task automatic drive(input logic pv, input logic [W-1:0] pd, input logic rdy, input logic fl);
    push_valid = pv;
    push_data  = pd;
    ready      = rdy;
    flush      = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push_valid = 1'b0;
    push_data  = '0;
    ready      = 1'b0;
    flush      = 1'b0;
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    push_valid = 1'b0;
    push_data  = '0;
    ready      = 1'b0;
    flush      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count",       W'(count),       W'(0));
    chk("rst_valid",       W'(valid_fifo),  W'(0));
    chk("rst_empty",       W'(empty),       W'(1));
    chk("rst_push_ready",  W'(push_ready),  W'(1));
    chk("rst_almost_full", W'(almost_full), W'(0));
    chk("rst_instruction", instruction,     W'(0));
    rst = 1'b0;

    // Ordering: three pushes held, then drained on consecutive cycles.
    drive(1'b1, W'('hA1), 1'b0, 1'b0);
    drive(1'b1, W'('hA2), 1'b0, 1'b0);
    drive(1'b1, W'('hA3), 1'b0, 1'b0);
    chk("ord_count3", W'(count), W'(3));
    push_valid = 1'b0;
    ready      = 1'b1;
    #1;
    chk("ord_head_a1", instruction, W'('hA1));
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("ord_head_a2", instruction, W'('hA2));
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("ord_head_a3", instruction, W'('hA3));
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("ord_valid_low", W'(valid_fifo), W'(0));
    chk("ord_count0",    W'(count),      W'(0));

    // Asynchronous reset mid-run with three entries stored.
    drive(1'b1, W'('h11), 1'b0, 1'b0);
    drive(1'b1, W'('h12), 1'b0, 1'b0);
    drive(1'b1, W'('h13), 1'b0, 1'b0);
    idle();
    rst = 1'b1;
    #1;
    chk("arst_count",      W'(count),      W'(0));
    chk("arst_valid",      W'(valid_fifo), W'(0));
    chk("arst_empty",      W'(empty),      W'(1));
    chk("arst_push_ready", W'(push_ready), W'(1));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Full: eight pushes, almost_full from count 6, refusal, wrap-around.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, W'('h100 + i), 1'b0, 1'b0);
      if (i == 4) chk("full_af_at5", W'(almost_full), W'(0));
      if (i == 5) chk("full_af_at6", W'(almost_full), W'(1));
    end
    chk("full_push_ready", W'(push_ready), W'(0));
    chk("full_count8",     W'(count),      W'(8));
    drive(1'b1, W'('h1FF), 1'b0, 1'b0);
    chk("full_held_count", W'(count), W'(8));
    chk("full_head",       instruction, W'('h100));
    drive(1'b1, W'('h1FF), 1'b1, 1'b0);
    chk("full_pop_count7", W'(count),      W'(7));
    chk("full_pop_ready",  W'(push_ready), W'(1));
    chk("full_pop_head",   instruction,    W'('h101));
    drive(1'b1, W'('h1FF), 1'b0, 1'b0);
    chk("full_refill8", W'(count), W'(8));
    for (int i = 0; i < DEPTH - 1; i++) drive(1'b0, '0, 1'b1, 1'b0);
    chk("wrap_head", instruction, W'('h1FF));
    chk("wrap_count", W'(count),  W'(1));
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("wrap_drained", W'(empty), W'(1));

    // Simultaneous push and pop at count 4.
    for (int i = 0; i < 4; i++) drive(1'b1, W'('hB0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, W'('hB5 + (i << 8)), 1'b1, 1'b0);
      chk("sim_count4", W'(count), W'(4));
    end
    chk("sim_head", instruction, W'('h6B5));
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, 1'b0);
    chk("sim_drained", W'(count), W'(0));

    // Flush with push and pop offered in the same cycle.
    for (int i = 0; i < 5; i++) drive(1'b1, W'('hE0 + i), 1'b0, 1'b0);
    drive(1'b1, W'('hEE), 1'b1, 1'b1);
    idle();
    chk("flush_count",      W'(count),      W'(0));
    chk("flush_valid",      W'(valid_fifo), W'(0));
    chk("flush_push_ready", W'(push_ready), W'(1));
    drive(1'b1, W'('hC0), 1'b0, 1'b0);
    idle();
    chk("flush_c0_head",  instruction,     W'('hC0));
    chk("flush_c0_valid", W'(valid_fifo),  W'(1));
    chk("flush_c0_count", W'(count),       W'(1));
    drive(1'b0, '0, 1'b1, 1'b0);

    // Empty FIFO offered 0xD7 with ready: same-cycle only in the bypass build.
    idle();
    push_valid = 1'b1;
    push_data  = W'('hD7);
    ready      = 1'b1;
    #1;
    chk("byp_valid", W'(valid_fifo), W'(BYP));
    chk("byp_instr", instruction,    BYP ? W'('hD7) : W'(0));
    @(posedge clk);
    #1;
    idle();
    chk("byp_count_after", W'(count),   BYP ? W'(0) : W'(1));
    chk("byp_instr_after", instruction, BYP ? W'(0) : W'('hD7));
    drive(1'b0, '0, 1'b1, 1'b0);
    idle();

    // Randomized traffic checked by the compare process every cycle.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 99) < 60),
            {$urandom, $urandom, $urandom},
            1'($urandom_range(0, 99) < 50),
            1'($urandom_range(0, 99) < 3));
    end
    idle();
    repeat (3) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
